tanh_host_sequencer: RTL and testbench

- Host-side initiator for the tanh accelerator controller.
- Accepts a stream of input samples and writes them into the input sample SRAM.
- Then pulses RUN to the controller and tracks its BUSY handshake.
- When the run ends, reads the result SRAM back and streams the results out with valid/ready flow control and a last marker.

---
 rtl/tanh_host_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_tanh_host_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_host_sequencer.sv
// ---------------------------------------------------------------------------
// tanh_host_sequencer
//
// Host-side initiator for the tanh accelerator controller. A job loads
// num_samples input words into the input SRAM, pulses RUN, follows the
// BUSY handshake, then reads the result SRAM back and streams it out.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   start, num_samples     job request and length (1..2^ADDR_W), IDLE only
//   in_valid/in_ready/in_data     input sample stream (accepted in LOAD)
//   mem_in_we/addr/wdata          input SRAM write port
//   RUN, BUSY                     controller start pulse / busy flag
//   mem_out_re/addr, mem_out_rdata result SRAM read port (1-cycle latency)
//   out_valid/out_ready/out_data/out_last  result stream
//   active, done, err             status: not-IDLE, job-complete pulse,
//                                 sticky error
// ---------------------------------------------------------------------------
module tanh_host_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              mem_in_we,
    output logic [ADDR_W-1:0] mem_in_addr,
    output logic [DATA_W-1:0] mem_in_wdata,
    output logic              RUN,
    input  logic              BUSY,
    output logic              mem_out_re,
    output logic [ADDR_W-1:0] mem_out_addr,
    input  logic [DATA_W-1:0] mem_out_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              active,
    output logic              done,
    output logic              err
);

    localparam int              TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   T_ONE  = TW'(1);
    localparam logic [ADDR_W:0] MAX_N  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_BUSY,
        RUNNING,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        n_q, n_d;
    logic [ADDR_W:0]        wcnt_q, wcnt_d;
    logic [ADDR_W:0]        rcnt_q, rcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   err_q, err_d;

    // Two-entry result FIFO plus one read in flight from the SRAM.
    logic [1:0][DATA_W-1:0] fifo_data_q;
    logic [1:0]             fifo_last_q;
    logic                   head_q;
    logic [1:0]             count_q;
    logic                   infl_q;
    logic                   infl_last_q;

    logic                   num_ok;
    logic [ADDR_W:0]        n_last;
    logic                   pop;
    logic                   head_last;
    logic                   tail;
    logic [2:0]             pending;
    logic                   rd_issue;

    assign num_ok    = (num_samples != '0) && (num_samples <= MAX_N);
    assign n_last    = n_q - 1'b1;
    assign head_last = fifo_last_q[head_q];
    assign tail      = head_q ^ count_q[0];

    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? fifo_data_q[head_q] : '0;
    assign out_last  = out_valid & head_last;
    assign pop       = out_valid & out_ready;

    // Slots still claimed once this cycle's pop leaves; counting the pop
    // lets a new read go out every cycle while the consumer keeps up.
    assign pending  = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
    assign rd_issue = (state_q == DRAIN) && (rcnt_q < n_q) && (pending < 3'd2);

    assign active = (state_q != IDLE);
    assign err    = err_q;

    // Next-state and handshake decode. tcnt holds the number of cycles
    // elapsed since the RUN cycle, so err lands exactly TIMEOUT cycles later.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        tcnt_d       = tcnt_q;
        err_d        = err_q;
        in_ready     = 1'b0;
        mem_in_we    = 1'b0;
        mem_in_addr  = '0;
        mem_in_wdata = '0;
        RUN          = 1'b0;
        mem_out_re   = 1'b0;
        mem_out_addr = '0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_ok) begin
                        n_d     = num_samples;
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_in_we    = 1'b1;
                    mem_in_addr  = wcnt_q[ADDR_W-1:0];
                    mem_in_wdata = in_data;
                    wcnt_d       = wcnt_q + 1'b1;
                    if (wcnt_q == n_last) begin
                        state_d = KICK;
                    end
                end
            end
            KICK: begin
                RUN     = 1'b1;
                tcnt_d  = T_ONE;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (BUSY) begin
                    state_d = RUNNING;
                end else if (tcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RUNNING: begin
                if (!BUSY) begin
                    rcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_issue) begin
                    mem_out_re   = 1'b1;
                    mem_out_addr = rcnt_q[ADDR_W-1:0];
                    rcnt_d       = rcnt_q + 1'b1;
                end
                if (pop && head_last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and result FIFO. Read data returns the cycle after
    // mem_out_re and is written at the tail in that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            tcnt_q      <= '0;
            err_q       <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            head_q      <= 1'b0;
            count_q     <= 2'd0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            tcnt_q      <= tcnt_d;
            err_q       <= err_d;
            infl_q      <= rd_issue;
            infl_last_q <= rd_issue && (rcnt_q == n_last);
            if (infl_q) begin
                fifo_data_q[tail] <= mem_out_rdata;
                fifo_last_q[tail] <= infl_last_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_tanh_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tanh_host_sequencer
//
// Directed bench for tanh_host_sequencer. Models the input SRAM, a result
// SRAM filled with (input ^ 16'h5A5A) while the controller is busy, and the
// BUSY behaviour of the controller. Outputs are sampled at the falling edge
// or 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_tanh_host_sequencer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 64;
    localparam logic [15:0] KEY = 16'h5A5A;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_samples = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              mem_in_we;
    logic [ADDR_W-1:0] mem_in_addr;
    logic [DATA_W-1:0] mem_in_wdata;
    logic              RUN;
    logic              BUSY = 1'b0;
    logic              mem_out_re;
    logic [ADDR_W-1:0] mem_out_addr;
    logic [DATA_W-1:0] mem_out_rdata;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              active;
    logic              done;
    logic              err;

    tanh_host_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .mem_in_we    (mem_in_we),
        .mem_in_addr  (mem_in_addr),
        .mem_in_wdata (mem_in_wdata),
        .RUN          (RUN),
        .BUSY         (BUSY),
        .mem_out_re   (mem_out_re),
        .mem_out_addr (mem_out_addr),
        .mem_out_rdata(mem_out_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .active       (active),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    // SRAM models
    logic [15:0] inMem  [0:4095];
    logic [15:0] resMem [0:4095];
    logic [15:0] rdataQ = '0;
    assign mem_out_rdata = rdataQ;

    always @(posedge clock) begin
        if (mem_in_we) inMem[mem_in_addr] <= mem_in_wdata;
        if (mem_out_re) rdataQ <= resMem[mem_out_addr];
    end

    logic anyOut;
    assign anyOut = |{in_ready, mem_in_we, mem_in_addr, mem_in_wdata, RUN, mem_out_re,
                      mem_out_addr, out_valid, out_data, out_last, active, done, err};

    // Falling-edge monitor: logs traffic and tracks FIFO occupancy
    int          cyc = 0;
    int          doneCnt = 0;
    logic [11:0] wrAddrQ[$];
    logic [15:0] wrDataQ[$];
    int          wrCycQ[$];
    logic [11:0] rdAddrQ[$];
    logic [15:0] outDataQ[$];
    bit          outLastQ[$];
    int          outCycQ[$];
    int          stallViol = 0, issueViol = 0, validViol = 0;
    bit          prevStall = 0;
    logic [15:0] prevData = '0;
    logic        prevLast = 1'b0;
    int          rdSeen = 0, pops = 0, monOcc = 0;
    bit          rePrev = 0, monPop = 0;

    always @(negedge clock) begin
        if (mem_in_we) begin
            wrAddrQ.push_back(mem_in_addr);
            wrDataQ.push_back(mem_in_wdata);
            wrCycQ.push_back(cyc);
        end
        if (mem_out_re) rdAddrQ.push_back(mem_out_addr);
        if (done) doneCnt++;
        if (out_valid && out_ready) begin
            outDataQ.push_back(out_data);
            outLastQ.push_back(out_last);
            outCycQ.push_back(cyc);
        end
        if (reset || RUN) begin
            prevStall = 0;
            rdSeen = 0;
            pops = 0;
            rePrev = 0;
        end else begin
            monPop = out_valid && out_ready;
            monOcc = rdSeen - int'(rePrev) - pops;
            if (mem_out_re && (monOcc + int'(rePrev) - int'(monPop) >= 2)) issueViol++;
            if (out_valid != (monOcc > 0)) validViol++;
            if (prevStall && (!out_valid || out_data != prevData || out_last != prevLast)) stallViol++;
            prevStall = out_valid && !out_ready;
            prevData = out_data;
            prevLast = out_last;
            rdSeen += int'(mem_out_re);
            rePrev = mem_out_re;
            pops += int'(monPop);
        end
        cyc++;
    end

    int total = 0;
    int bad = 0;
    int rdBase = 0, outBase = 0, doneBase = 0;
    int stallBase = 0, issueBase = 0, validBase = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Request a job and confirm it entered LOAD
    task automatic startJob(input int n, input bit hold);
        start = 1'b1;
        num_samples = (ADDR_W+1)'(n);
        tick();
        if (!hold) start = 1'b0;
        checkOutput("accept_active", active, 1);
        checkOutput("accept_err_clear", err, 0);
        checkOutput("load_in_ready", in_ready, 1);
    endtask

    // Stream n samples back-to-back; returns in the KICK cycle
    task automatic loadJob(input int n, input logic [15:0] base);
        int wb;
        int errs;
        wb = wrAddrQ.size();
        errs = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = base + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        checkOutput("wr_count", wrAddrQ.size() - wb, n);
        if (wrAddrQ.size() - wb == n) begin
            for (int i = 0; i < n; i++)
                if (wrAddrQ[wb+i] != 12'(i) || wrDataQ[wb+i] != base + 16'(i)) errs++;
            checkOutput("wr_back_to_back", wrCycQ[wb+n-1] - wrCycQ[wb], n - 1);
        end else begin
            errs = n;
        end
        checkOutput("wr_addr_data", errs, 0);
        checkOutput("kick_run", RUN, 1);
        checkOutput("kick_in_ready", in_ready, 0);
    endtask

    // Controller model: BUSY rises after 'delay' cycles and holds for 'len'
    task automatic busyPhase(input int n, input int delay, input int len, output int fallCyc);
        rdBase = rdAddrQ.size();
        outBase = outDataQ.size();
        doneBase = doneCnt;
        stallBase = stallViol;
        issueBase = issueViol;
        validBase = validViol;
        tick();
        checkOutput("run_one_cycle", RUN, 0);
        repeat (delay) tick();
        for (int i = 0; i < n; i++) resMem[i] = inMem[i] ^ KEY;
        BUSY = 1'b1;
        repeat (len) tick();
        checkOutput("running_active", active, 1);
        BUSY = 1'b0;
        fallCyc = cyc;
    endtask

    // Drain results; mode 0 = ready always, mode 1 = ready 1,0,0 repeating
    task automatic drainJob(input int n, input logic [15:0] base, input int mode,
                            input int fallCyc, input int stopAfter);
        bit finished;
        int errs;
        int lastErrs;
        finished = 0;
        errs = 0;
        lastErrs = 0;
        for (int k = 0; k < 4 * n + 50; k++) begin
            out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            tick();
            if (doneCnt != doneBase) begin
                finished = 1;
                break;
            end
            if (stopAfter != 0 && outDataQ.size() - outBase >= stopAfter) break;
        end
        out_ready = 1'b0;
        if (stopAfter == 0) begin
            checkOutput("drain_finished", finished, 1);
            checkOutput("idle_after_done", active, 0);
            checkOutput("done_one_pulse", doneCnt - doneBase, 1);
            checkOutput("rd_count", rdAddrQ.size() - rdBase, n);
            checkOutput("out_count", outDataQ.size() - outBase, n);
            if (rdAddrQ.size() - rdBase == n && outDataQ.size() - outBase == n) begin
                for (int i = 0; i < n; i++) begin
                    if (rdAddrQ[rdBase+i] != 12'(i)) errs++;
                    if (outDataQ[outBase+i] != ((base + 16'(i)) ^ KEY)) errs++;
                    if (outLastQ[outBase+i] != (i == n - 1)) lastErrs++;
                end
                if (mode == 0) begin
                    checkOutput("first_out_latency", outCycQ[outBase], fallCyc + 3);
                    checkOutput("out_throughput", outCycQ[outBase+n-1] - outCycQ[outBase], n - 1);
                end
            end else begin
                errs = n;
            end
            checkOutput("rd_addr_out_data", errs, 0);
            checkOutput("out_last_position", lastErrs, 0);
            checkOutput("stall_stable", stallViol - stallBase, 0);
            checkOutput("issue_limit", issueViol - issueBase, 0);
            checkOutput("valid_vs_occupancy", validViol - validBase, 0);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [15:0] base, input int mode, input bit hold);
        int fall;
        startJob(n, hold);
        loadJob(n, base);
        busyPhase(n, 2, 10, fall);
        drainJob(n, base, mode, fall, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fall;
        int wb;
        int rb;
        int db;

        // Reset state
        repeat (3) tick();
        checkOutput("reset_outputs", anyOut, 0);
        reset = 1'b0;
        tick();
        checkOutput("idle_outputs", anyOut, 0);

        // Basic job, then one with a stalling consumer
        applyStimulus(4, 16'h0010, 0, 0);
        applyStimulus(3, 16'h0100, 1, 0);

        // BUSY never rises; BUSY in the KICK cycle must not count
        startJob(2, 0);
        loadJob(2, 16'h0200);
        db = doneCnt;
        BUSY = 1'b1;
        tick();
        BUSY = 1'b0;
        checkOutput("wait_run_low", RUN, 0);
        repeat (TIMEOUT - 2) tick();
        checkOutput("timeout_err_not_early", err, 0);
        checkOutput("timeout_still_waiting", active, 1);
        tick();
        checkOutput("timeout_err", err, 1);
        checkOutput("timeout_idle", active, 0);
        checkOutput("timeout_no_done", doneCnt - db, 0);
        applyStimulus(1, 16'h0AB0, 0, 0);

        // Illegal lengths
        wb = wrAddrQ.size();
        rb = rdAddrQ.size();
        start = 1'b1;
        num_samples = '0;
        tick();
        start = 1'b0;
        checkOutput("zero_len_err", err, 1);
        checkOutput("zero_len_idle", active, 0);
        tick();
        start = 1'b1;
        num_samples = 13'd4097;
        tick();
        start = 1'b0;
        checkOutput("over_len_idle", active, 0);
        checkOutput("illegal_no_sram", (wrAddrQ.size() - wb) + (rdAddrQ.size() - rb), 0);

        // Full-depth job
        applyStimulus(4096, 16'h1000, 0, 0);
        checkOutput("last_wr_addr", wrAddrQ[wrAddrQ.size()-1], 12'hFFF);
        checkOutput("last_rd_addr", rdAddrQ[rdAddrQ.size()-1], 12'hFFF);

        // Reset in the middle of draining
        startJob(5, 0);
        loadJob(5, 16'h0300);
        busyPhase(5, 1, 4, fall);
        drainJob(5, 16'h0300, 0, fall, 2);
        checkOutput("draining_before_reset", active, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs", anyOut, 0);
        rb = rdAddrQ.size();
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        checkOutput("no_read_after_reset", rdAddrQ.size() - rb, 0);
        checkOutput("idle_after_reset", active, 0);
        applyStimulus(1, 16'h0777, 0, 0);

        // start held high for a whole job, then accepted right after done
        applyStimulus(2, 16'h0400, 0, 1);
        tick();
        checkOutput("restart_accept_active", active, 1);
        checkOutput("restart_accept_ready", in_ready, 1);
        start = 1'b0;
        loadJob(2, 16'h0500);
        busyPhase(2, 0, 3, fall);
        drainJob(2, 16'h0500, 1, fall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
